// File: rtl/keypad_pin_encoder.sv
`timescale 1ns/1ps
// Keypad PIN entry and arm/disarm command encoder for the alarm's 4-bit keypad bus.
// Collects digits, checks the PIN, counts bad attempts and enforces a lockout.
module keypad_pin_encoder #(
  parameter int unsigned            PIN_LEN  = 4,
  parameter logic [4*PIN_LEN-1:0]   PIN      = 16'h1234,
  parameter int unsigned            TIMEOUT  = 200,
  parameter int unsigned            MAX_FAIL = 3,
  parameter int unsigned            LOCKOUT  = 1000,
  parameter int unsigned            HOLD     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_code,
  output logic [3:0] o_keypad,
  output logic       o_entry_active,
  output logic       o_locked_out,
  output logic       o_bad_pin
);

  localparam int unsigned DIG_W  = 4 * PIN_LEN;
  localparam int unsigned CNT_W  = $clog2(PIN_LEN + 2);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned LCK_W  = $clog2(LOCKOUT + 1);
  localparam int unsigned HLD_W  = $clog2(HOLD + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_CMD   = 2'd2;
  localparam logic [1:0] S_LOCK  = 2'd3;

  localparam logic [3:0] KEY_ARM     = 4'hA;
  localparam logic [3:0] KEY_DISARM  = 4'hB;
  localparam logic [3:0] KEY_CLEAR   = 4'hF;
  localparam logic [3:0] CODE_IDLE   = 4'b0000;
  localparam logic [3:0] CODE_ARM    = 4'b0011;
  localparam logic [3:0] CODE_DISARM = 4'b1100;

  logic [1:0]        r_state;
  logic [DIG_W-1:0]  r_digits;
  logic [CNT_W-1:0]  r_count;
  logic [TMO_W-1:0]  r_tmo;
  logic [LCK_W-1:0]  r_lock_cnt;
  logic [HLD_W-1:0]  r_hold_cnt;
  logic [FAIL_W-1:0] r_fail_cnt;
  logic [3:0]        r_keypad;
  logic              r_entry_active;
  logic              r_locked_out;
  logic              r_bad_pin;

  logic [1:0]        w_state_nx;
  logic [DIG_W-1:0]  w_digits_nx;
  logic [CNT_W-1:0]  w_count_nx;
  logic [TMO_W-1:0]  w_tmo_nx;
  logic [LCK_W-1:0]  w_lock_nx;
  logic [HLD_W-1:0]  w_hold_nx;
  logic [FAIL_W-1:0] w_fail_nx;
  logic [3:0]        w_keypad_nx;
  logic              w_bad_pin_nx;
  logic              w_reject;
  logic              w_is_digit;
  logic              w_is_cmd;
  logic              w_is_clear;
  logic              w_pin_ok;

  assign w_is_digit = i_key_valid && (i_key_code <= 4'd9);
  assign w_is_cmd   = i_key_valid && ((i_key_code == KEY_ARM) || (i_key_code == KEY_DISARM));
  assign w_is_clear = i_key_valid && (i_key_code == KEY_CLEAR);
  // An overflowed count never equals PIN_LEN, so extra digits always fail.
  assign w_pin_ok   = (r_count == CNT_W'(PIN_LEN)) && (r_digits == PIN);

  // Next-state and next-output logic
  always_comb begin
    w_state_nx   = r_state;
    w_digits_nx  = r_digits;
    w_count_nx   = r_count;
    w_tmo_nx     = r_tmo;
    w_lock_nx    = r_lock_cnt;
    w_hold_nx    = r_hold_cnt;
    w_fail_nx    = r_fail_cnt;
    w_keypad_nx  = r_keypad;
    w_bad_pin_nx = 1'b0;
    w_reject     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_is_digit) begin
          w_state_nx  = S_ENTRY;
          w_digits_nx = DIG_W'(i_key_code);
          w_count_nx  = CNT_W'(1);
          w_tmo_nx    = '0;
        end else if (w_is_cmd) begin
          w_reject = 1'b1;
        end
      end
      S_ENTRY: begin
        if (w_is_digit) begin
          w_digits_nx = (r_digits << 4) | DIG_W'(i_key_code);
          if (r_count <= CNT_W'(PIN_LEN)) w_count_nx = r_count + CNT_W'(1);
          w_tmo_nx = '0;
        end else if (w_is_clear) begin
          w_state_nx  = S_IDLE;
          w_digits_nx = '0;
          w_count_nx  = '0;
          w_tmo_nx    = '0;
        end else if (w_is_cmd) begin
          if (w_pin_ok) begin
            w_state_nx  = S_CMD;
            w_fail_nx   = '0;
            w_hold_nx   = HLD_W'(1);
            w_keypad_nx = (i_key_code == KEY_ARM) ? CODE_ARM : CODE_DISARM;
            w_digits_nx = '0;
            w_count_nx  = '0;
            w_tmo_nx    = '0;
          end else begin
            w_reject = 1'b1;
          end
        end else if (r_tmo == TMO_W'(TIMEOUT)) begin
          w_state_nx  = S_IDLE;
          w_digits_nx = '0;
          w_count_nx  = '0;
          w_tmo_nx    = '0;
        end else begin
          w_tmo_nx = r_tmo + TMO_W'(1);
        end
      end
      S_CMD: begin
        if (r_hold_cnt == HLD_W'(HOLD)) begin
          w_state_nx  = S_IDLE;
          w_keypad_nx = CODE_IDLE;
          w_hold_nx   = '0;
        end else begin
          w_hold_nx = r_hold_cnt + HLD_W'(1);
        end
      end
      S_LOCK: begin
        if (r_lock_cnt == LCK_W'(LOCKOUT)) begin
          w_state_nx = S_IDLE;
          w_fail_nx  = '0;
          w_lock_nx  = '0;
        end else begin
          w_lock_nx = r_lock_cnt + LCK_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // A rejected attempt clears the entry and may start the lockout
    if (w_reject) begin
      w_bad_pin_nx = 1'b1;
      w_digits_nx  = '0;
      w_count_nx   = '0;
      w_tmo_nx     = '0;
      w_fail_nx    = r_fail_cnt + FAIL_W'(1);
      if (r_fail_cnt >= FAIL_W'(MAX_FAIL - 1)) begin
        w_state_nx = S_LOCK;
        w_lock_nx  = LCK_W'(1);
      end else begin
        w_state_nx = S_IDLE;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_digits       <= '0;
      r_count        <= '0;
      r_tmo          <= '0;
      r_lock_cnt     <= '0;
      r_hold_cnt     <= '0;
      r_fail_cnt     <= '0;
      r_keypad       <= CODE_IDLE;
      r_entry_active <= 1'b0;
      r_locked_out   <= 1'b0;
      r_bad_pin      <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_digits       <= w_digits_nx;
      r_count        <= w_count_nx;
      r_tmo          <= w_tmo_nx;
      r_lock_cnt     <= w_lock_nx;
      r_hold_cnt     <= w_hold_nx;
      r_fail_cnt     <= w_fail_nx;
      r_keypad       <= w_keypad_nx;
      r_entry_active <= (w_state_nx == S_ENTRY);
      r_locked_out   <= (w_state_nx == S_LOCK);
      r_bad_pin      <= w_bad_pin_nx;
    end
  end

  assign o_keypad       = r_keypad;
  assign o_entry_active = r_entry_active;
  assign o_locked_out   = r_locked_out;
  assign o_bad_pin      = r_bad_pin;

endmodule

// File: tb/tb_keypad_pin_encoder.sv
`timescale 1ns/1ps
// Self-checking bench for keypad_pin_encoder: a per-cycle vector table for the
// basic arm/disarm/reject flows plus directed lockout, timeout and reset sequences.
module tb_keypad_pin_encoder;

  localparam int unsigned LOCKOUT = 1000;
  localparam int unsigned TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] keypad;
  logic       entry_active;
  logic       locked_out;
  logic       bad_pin;

  int checks   = 0;
  int failures = 0;
  logic bp_seen;

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic [3:0] kp;
    logic       ea;
    logic       lo;
    logic       bp;
  } vec_t;

  vec_t vecs[$];

  keypad_pin_encoder dut (
    .clk            (clk),
    .reset          (reset),
    .i_key_valid    (key_valid),
    .i_key_code     (key_code),
    .o_keypad       (keypad),
    .o_entry_active (entry_active),
    .o_locked_out   (locked_out),
    .o_bad_pin      (bad_pin)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic kv, input logic [3:0] kc, input logic [3:0] kp,
                     input logic ea, input logic lo, input logic bp);
    vec_t v;
    v.kv = kv; v.kc = kc; v.kp = kp; v.ea = ea; v.lo = lo; v.bp = bp;
    vecs.push_back(v);
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    if (bad_pin) bp_seen = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bad_pin) bp_seen = 1'b1;
    end
  endtask

  initial begin
    int cnt;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    bp_seen   = 1'b0;

    // Arm with correct PIN
    add(1, 4'h1, 4'h0, 1, 0, 0); add(1, 4'h2, 4'h0, 1, 0, 0);
    add(1, 4'h3, 4'h0, 1, 0, 0); add(1, 4'h4, 4'h0, 1, 0, 0);
    add(1, 4'hA, 4'h3, 0, 0, 0); add(0, 4'h0, 4'h3, 0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0);
    // Disarm with correct PIN
    add(1, 4'h1, 4'h0, 1, 0, 0); add(1, 4'h2, 4'h0, 1, 0, 0);
    add(1, 4'h3, 4'h0, 1, 0, 0); add(1, 4'h4, 4'h0, 1, 0, 0);
    add(1, 4'hB, 4'hC, 0, 0, 0); add(0, 4'h0, 4'hC, 0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0);
    // Wrong digit
    add(1, 4'h1, 4'h0, 1, 0, 0); add(1, 4'h2, 4'h0, 1, 0, 0);
    add(1, 4'h3, 4'h0, 1, 0, 0); add(1, 4'h5, 4'h0, 1, 0, 0);
    add(1, 4'hA, 4'h0, 0, 0, 1); add(0, 4'h0, 4'h0, 0, 0, 0);
    // Too few digits
    add(1, 4'h1, 4'h0, 1, 0, 0); add(1, 4'h2, 4'h0, 1, 0, 0);
    add(1, 4'h3, 4'h0, 1, 0, 0);
    add(1, 4'hA, 4'h0, 0, 0, 1); add(0, 4'h0, 4'h0, 0, 0, 0);
    // Too many digits: third failure locks out
    add(1, 4'h1, 4'h0, 1, 0, 0); add(1, 4'h2, 4'h0, 1, 0, 0);
    add(1, 4'h3, 4'h0, 1, 0, 0); add(1, 4'h4, 4'h0, 1, 0, 0);
    add(1, 4'h4, 4'h0, 1, 0, 0);
    add(1, 4'hA, 4'h0, 0, 1, 1);
    // Keys ignored while locked
    add(1, 4'h1, 4'h0, 0, 1, 0); add(1, 4'h2, 4'h0, 0, 1, 0);
    add(1, 4'h3, 4'h0, 0, 1, 0); add(1, 4'h4, 4'h0, 0, 1, 0);
    add(1, 4'hA, 4'h0, 0, 1, 0);

    // Reset held 10 cycles
    idle(10);
    chk("reset_keypad", 16'(keypad), 16'h0);
    chk("reset_entry", 16'(entry_active), 16'h0);
    chk("reset_locked", 16'(locked_out), 16'h0);
    chk("reset_badpin", 16'(bad_pin), 16'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      key_valid = vecs[i].kv;
      key_code  = vecs[i].kc;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_keypad", i), 16'(keypad), 16'(vecs[i].kp));
      chk($sformatf("vec%0d_entry", i), 16'(entry_active), 16'(vecs[i].ea));
      chk($sformatf("vec%0d_locked", i), 16'(locked_out), 16'(vecs[i].lo));
      chk($sformatf("vec%0d_badpin", i), 16'(bad_pin), 16'(vecs[i].bp));
    end
    key_valid = 1'b0;
    key_code  = 4'h0;

    // Lockout lasts LOCKOUT cycles from the rejecting edge; 5 already elapsed
    cnt = 0;
    while (locked_out && cnt < 2 * LOCKOUT) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("lockout_remaining", 16'(cnt), 16'(LOCKOUT - 5));
    chk("lockout_released", 16'(locked_out), 16'h0);

    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    chk("post_lock_arm", 16'(keypad), 16'h3);
    idle(2);
    chk("post_lock_idle", 16'(keypad), 16'h0);

    // Inter-key timeout: TIMEOUT idle cycles tolerated, one more drops entry
    bp_seen = 1'b0;
    press(4'h1); press(4'h2);
    idle(TIMEOUT);
    chk("tmo_still_active", 16'(entry_active), 16'h1);
    idle(1);
    chk("tmo_dropped", 16'(entry_active), 16'h0);
    chk("tmo_no_badpin", 16'(bp_seen), 16'h0);
    press(4'h3); press(4'h4); press(4'hA);
    chk("tmo_then_reject", 16'(bad_pin), 16'h1);
    chk("tmo_reject_keypad", 16'(keypad), 16'h0);

    // Clear is not a failure: two rejects plus a clear must not lock
    press(4'h1); press(4'hF);
    chk("clear_entry", 16'(entry_active), 16'h0);
    chk("clear_badpin", 16'(bad_pin), 16'h0);
    press(4'h9); press(4'hA);
    chk("second_reject", 16'(bad_pin), 16'h1);
    chk("no_lock_after_clear", 16'(locked_out), 16'h0);
    press(4'h1); press(4'h2); press(4'hF);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    chk("clear_then_arm", 16'(keypad), 16'h3);
    idle(1);
    chk("clear_arm_hold", 16'(keypad), 16'h3);
    idle(1);
    chk("clear_arm_end", 16'(keypad), 16'h0);

    // C/D/E ignored: no entry from idle, no timeout restart
    press(4'hD);
    chk("ignore_idle", 16'(entry_active), 16'h0);
    press(4'h1);
    idle(100);
    press(4'hC);
    idle(TIMEOUT - 101);
    chk("ignore_tmo_active", 16'(entry_active), 16'h1);
    idle(1);
    chk("ignore_tmo_dropped", 16'(entry_active), 16'h0);

    // Command key from idle is a reject
    press(4'hB);
    chk("idle_cmd_reject", 16'(bad_pin), 16'h1);
    chk("idle_cmd_keypad", 16'(keypad), 16'h0);

    // Reset during the first hold cycle
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    chk("pre_reset_arm", 16'(keypad), 16'h3);
    reset = 1'b1;
    idle(1);
    chk("midcmd_reset_keypad", 16'(keypad), 16'h0);
    chk("midcmd_reset_entry", 16'(entry_active), 16'h0);
    reset = 1'b0;
    idle(2);
    chk("after_reset_keypad", 16'(keypad), 16'h0);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hB);
    chk("after_reset_disarm", 16'(keypad), 16'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
